// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, one quotient bit per clock, valid/ready on both sides
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes on the edge after acceptance instead of running N steps.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(DIVIDEND_W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state;
  logic [DIVIDEND_W-1:0] dvd, dvd_nx;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W:0]    r, r_sh, r_nx;
  logic [CW-1:0]         cnt;
  logic                  q_bit, last;
  assign in_ready = state == IDLE;
  // Quotient bits fill the dividend register from the bottom as its bits leave the top.
  always_comb begin
    r_sh   = {r[DIVISOR_W-1:0], dvd[DIVIDEND_W-1]};
    q_bit  = r_sh >= {1'b0, dsr};
    r_nx   = q_bit ? r_sh - {1'b0, dsr} : r_sh;
    dvd_nx = {dvd[DIVIDEND_W-2:0], q_bit};
    last   = cnt == CW'(DIVIDEND_W - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      r           <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd   <= dividend;
          dsr   <= divisor;
          r     <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN:
`ifdef DIV_ZERO_FAST_EN
          if (dsr == '0) begin
            quotient    <= '1;
            remainder   <= dvd[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else
`endif
          begin
            dvd <= dvd_nx;
            r   <= r_nx;
            if (last) begin
              quotient    <= dvd_nx;
              remainder   <= r_nx[DIVISOR_W-1:0];
              div_by_zero <= dsr == '0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else cnt <= cnt + 1'b1;
          end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench; driver queues expected results, negedge monitor compares them
module tb_seq_restoring_divider;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [7:0] dividend = 0, quotient;
  logic [3:0] divisor = 0, remainder;
  logic       in_ready, out_valid, div_by_zero, pv = 0;
  int         cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [7:0] q; logic [3:0] r; logic z; int lat; int acc;} exp_t;
  exp_t sb[$];
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 8;
`endif
  seq_restoring_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask
  // Monitor: latency on the rising edge of out_valid, values at the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && !pv) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else chk("latency", cyc - sb[0].acc, sb[0].lat);
    end
    if (rst_n && out_valid && out_ready && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", div_by_zero, e.z);
    end
    pv = out_valid;
  end
  task automatic send(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                      input logic [3:0] r, input logic z, input int lat, input bit push);
    int n = 0;
    exp_t e;
    in_valid = 1; dividend = a; divisor = b;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
    e.q = q; e.r = r; e.z = z; e.lat = lat; e.acc = cyc;
    if (push) sb.push_back(e);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("drain_timeout", 1, 0);
  endtask
  logic [7:0] da [6] = '{200, 255, 9, 0, 255, 8'hA5};
  logic [3:0] db [6] = '{7, 1, 15, 5, 15, 0};
  logic [7:0] dq [6] = '{28, 255, 0, 0, 17, 8'hFF};
  logic [3:0] dr [6] = '{4, 0, 9, 0, 0, 5};
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    for (int i = 0; i < 6; i++)
      send(da[i], db[i], dq[i], dr[i], db[i] == 0, db[i] == 0 ? ZLAT : 8, 1);
    wait_idle();
    // Backpressure: result must hold while in_valid pulses are ignored.
    out_ready = 0;
    send(200, 7, 28, 4, 0, 8, 1);
    for (int n = 0; n < 100 && !out_valid; n++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_quotient", quotient, 28);
      chk("bp_remainder", remainder, 4);
      chk("bp_in_ready", in_ready, 0);
      in_valid = i[0]; dividend = 8'h33; divisor = 4'h2;
    end
    in_valid = 0; out_ready = 1;
    wait_idle();
    // Reset in the middle of RUN discards the operation.
    send(100, 3, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1 chk("midrst_no_output", out_valid, 0);
    send(100, 3, 33, 1, 0, 8, 1);
    wait_idle();
    // Back-to-back random vectors, out_ready held high.
    for (int i = 0; i < 50; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(1, 15));
      send(a, b, a / 8'(b), 4'(a % 8'(b)), 0, 8, 1);
    end
    wait_idle();
    repeat (12) @(posedge clk);
    #1 chk("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
